// File: rtl/triangle_monitor.sv
// Receiver-side checker for an N-bit 0..MAX..0 triangle stream: tracks ramp direction and flags turnarounds and errors.
// Optional trough-to-trough period measurement is enabled by defining TRIANGLE_MONITOR_PERIOD_EN.
module triangle_monitor #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [N-1:0] in,
  output logic         dir,
  output logic         locked,
  output logic         peak,
  output logic         trough,
  output logic         error,
  output logic [N:0]   period,
  output logic         period_valid
);

  typedef enum logic [1:0] {IDLE, ACQUIRE, UP, DOWN} state_t;

  localparam logic [N:0] MAX  = {1'b0, {N{1'b1}}};
  localparam logic [N:0] ZERO = '0;
  localparam logic [N:0] ONE  = {{N{1'b0}}, 1'b1};

  state_t       state_q, state_d;
  logic [N-1:0] p_q, p_d;
  logic         dir_q, dir_d;
  logic         locked_q, locked_d;
  logic         peak_q, peak_d;
  logic         trough_q, trough_d;
  logic         error_q, error_d;

  logic [N:0] in_x, p_x;
  logic       is_inc, is_dec;

  // Widened compare so MAX->0 and 0->MAX can never look like a unit step.
  always_comb begin
    in_x   = {1'b0, in};
    p_x    = {1'b0, p_q};
    is_inc = (in_x == p_x + ONE);
    is_dec = (in_x + ONE == p_x);
  end

  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    locked_d = locked_q;
    peak_d   = 1'b0;
    trough_d = 1'b0;
    error_d  = 1'b0;
    if (ena) begin
      p_d = in;
      unique case (state_q)
        IDLE: state_d = ACQUIRE;
        ACQUIRE: begin
          if (is_inc)      state_d = UP;
          else if (is_dec) state_d = DOWN;
          else             error_d = 1'b1;
        end
        UP: begin
          if (is_inc) begin
            state_d = UP;
          end else if (p_x == MAX && in_x == MAX - ONE) begin
            state_d  = DOWN;
            peak_d   = 1'b1;
            locked_d = 1'b1;
          end else begin
            state_d = ACQUIRE;
            error_d = 1'b1;
          end
        end
        DOWN: begin
          if (is_dec) begin
            state_d = DOWN;
          end else if (p_x == ZERO && in_x == ONE) begin
            state_d  = UP;
            trough_d = 1'b1;
            locked_d = 1'b1;
          end else begin
            state_d = ACQUIRE;
            error_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
      if (error_d) locked_d = 1'b0;
    end
    dir_d = (state_d == DOWN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      p_q      <= '0;
      dir_q    <= 1'b0;
      locked_q <= 1'b0;
      peak_q   <= 1'b0;
      trough_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      dir_q    <= dir_d;
      locked_q <= locked_d;
      peak_q   <= peak_d;
      trough_q <= trough_d;
      error_q  <= error_d;
    end
  end

  assign dir    = dir_q;
  assign locked = locked_q;
  assign peak   = peak_q;
  assign trough = trough_q;
  assign error  = error_q;

`ifdef TRIANGLE_MONITOR_PERIOD_EN
  logic [N:0] cnt_q, cnt_d;
  logic [N:0] period_q, period_d;
  logic       period_valid_q, period_valid_d;
  logic       armed_q, armed_d;

  // The first trough after reset/error only arms; later troughs publish count+1.
  always_comb begin
    cnt_d          = cnt_q;
    period_d       = period_q;
    period_valid_d = period_valid_q;
    armed_d        = armed_q;
    if (ena) begin
      if (error_d) begin
        armed_d        = 1'b0;
        period_valid_d = 1'b0;
      end else if (trough_d) begin
        if (armed_q) begin
          period_d       = (cnt_q == '1) ? cnt_q : cnt_q + ONE;
          period_valid_d = 1'b1;
        end
        armed_d = 1'b1;
        cnt_d   = '0;
      end else if (state_q == UP || state_q == DOWN) begin
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      armed_q        <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      armed_q        <= armed_d;
    end
  end

  assign period       = period_q;
  assign period_valid = period_valid_q;
`else
  assign period       = '0;
  assign period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_triangle_monitor.sv
// Scoreboard bench for triangle_monitor: directed triangle streams push expected flags; a monitor pops and compares.
// Period expectations follow TRIANGLE_MONITOR_PERIOD_EN (zero when undefined).
module tb_triangle_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] in  = 8'd0;
  logic       dir, locked, peak, trough, error, period_valid;
  logic [8:0] period;

  typedef struct {
    logic       dir;
    logic       locked;
    logic       peak;
    logic       trough;
    logic       error;
    logic [8:0] period;
    logic       pv;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   checks  = 0;
  int   errors  = 0;
  logic took    = 1'b0;
  logic started = 1'b0;
  logic gaps    = 1'b0;
  logic       lk  = 1'b0;
  logic [8:0] per = 9'd0;
  logic       pv  = 1'b0;

  triangle_monitor #(.N(8)) dut (
    .clk(clk), .rst(rst), .ena(ena), .in(in),
    .dir(dir), .locked(locked), .peak(peak), .trough(trough), .error(error),
    .period(period), .period_valid(period_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] perExp(input logic [8:0] v);
`ifdef TRIANGLE_MONITOR_PERIOD_EN
    return v;
`else
    return 9'd0;
`endif
  endfunction

  function automatic logic pvExp(input logic v);
`ifdef TRIANGLE_MONITOR_PERIOD_EN
    return v;
`else
    return 1'b0;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [8:0] act, input logic [8:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] s, input logic d, input logic pk,
                               input logic tr, input logic er);
    exp_t e;
    if (gaps && $urandom_range(0, 3) == 0) begin
      ena = 1'b0;
      in  = 8'($urandom_range(0, 255));
      repeat ($urandom_range(1, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    rst = 1'b0;
    ena = 1'b1;
    in  = s;
    e.dir = d; e.locked = lk; e.peak = pk; e.trough = tr; e.error = er;
    e.period = perExp(per); e.pv = pvExp(pv);
    sb.push_back(e);
    @(posedge clk);
    #1;
    ena = 1'b0;
  endtask

  task automatic doReset(input logic with_ena);
    exp_t e;
    lk = 1'b0; per = 9'd0; pv = 1'b0;
    rst = 1'b1;
    ena = with_ena;
    in  = 8'd123;
    e.dir = 0; e.locked = 0; e.peak = 0; e.trough = 0; e.error = 0; e.period = 0; e.pv = 0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ena = 1'b0;
  endtask

  task automatic rampUp(input int a, input int b);
    for (int v = a; v <= b; v++) applyStimulus(8'(v), 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rampDown(input int a, input int b);
    for (int v = a; v >= b; v--) applyStimulus(8'(v), 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  always @(posedge clk) took <= ena || rst;

  // Pop one expectation per consumed edge; on idle edges pulses must be low and levels must hold.
  always @(negedge clk) begin
    if (took) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL scoreboard_underflow actual=0 required=1 at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("dir", 9'(dir), 9'(e.dir));
        checkOutput("locked", 9'(locked), 9'(e.locked));
        checkOutput("peak", 9'(peak), 9'(e.peak));
        checkOutput("trough", 9'(trough), 9'(e.trough));
        checkOutput("error", 9'(error), 9'(e.error));
        checkOutput("period", period, e.period);
        checkOutput("period_valid", 9'(period_valid), 9'(e.pv));
        last    = e;
        started = 1'b1;
      end
    end else if (started) begin
      checkOutput("idle_pulses", {6'd0, peak, trough, error}, 9'd0);
      checkOutput("idle_dir", 9'(dir), 9'(last.dir));
      checkOutput("idle_locked", 9'(locked), 9'(last.locked));
      checkOutput("idle_period", period, last.period);
      checkOutput("idle_period_valid", 9'(period_valid), 9'(last.pv));
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    doReset(1'b0);
    doReset(1'b1);

    // Clean ramp up to the first peak and down to the arming trough.
    applyStimulus(8'd0, 0, 0, 0, 0);
    rampUp(1, 255);
    lk = 1'b1;
    applyStimulus(8'd254, 1, 1, 0, 0);
    rampDown(253, 0);
    applyStimulus(8'd1, 0, 0, 1, 0);

    // Second period with random idle gaps; second trough publishes 510.
    gaps = 1'b1;
    rampUp(2, 255);
    applyStimulus(8'd254, 1, 1, 0, 0);
    rampDown(253, 0);
    per = 9'd510; pv = 1'b1;
    applyStimulus(8'd1, 0, 0, 1, 0);
    gaps = 1'b0;

    // Bad step 100 -> 102, then 103 re-acquires UP without a turnaround pulse.
    rampUp(2, 100);
    lk = 1'b0; pv = 1'b0;
    applyStimulus(8'd102, 0, 0, 0, 1);
    applyStimulus(8'd103, 0, 0, 0, 0);

    // Illegal wrap 255 -> 0, then a repeated sample while ramping down.
    rampUp(104, 255);
    applyStimulus(8'd0, 0, 0, 0, 1);
    applyStimulus(8'd42, 0, 0, 0, 1);
    applyStimulus(8'd41, 1, 0, 0, 0);
    applyStimulus(8'd40, 1, 0, 0, 0);
    applyStimulus(8'd40, 0, 0, 0, 1);

    // Re-acquire downward, re-arm on a trough and measure another full period.
    applyStimulus(8'd2, 0, 0, 0, 1);
    applyStimulus(8'd1, 1, 0, 0, 0);
    applyStimulus(8'd0, 1, 0, 0, 0);
    lk = 1'b1;
    applyStimulus(8'd1, 0, 0, 1, 0);
    rampUp(2, 255);
    applyStimulus(8'd254, 1, 1, 0, 0);
    rampDown(253, 0);
    per = 9'd510; pv = 1'b1;
    applyStimulus(8'd1, 0, 0, 1, 0);

    // Reset mid-stream at 77 while ramping down, then restart cleanly.
    rampUp(2, 255);
    applyStimulus(8'd254, 1, 1, 0, 0);
    rampDown(253, 77);
    doReset(1'b1);
    applyStimulus(8'd5, 0, 0, 0, 0);
    applyStimulus(8'd6, 0, 0, 0, 0);

    ena = 1'b0;
    repeat (4) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
